// File: rtl/issue_sched_if.sv
// Fetch-to-decode issue bus for issue_sched: fetched pair, hazard controls and issue slots.
interface issue_sched_if #(
   parameter int unsigned INST_W = 32,
   parameter int unsigned ADDR_W = 7
);
   logic              fe_valid;
   logic              fe_ready;
   logic [INST_W-1:0] fe_inst0;
   logic [INST_W-1:0] fe_inst1;
   logic              fe_pipe0;
   logic              fe_pipe1;
   logic              fe_wr0;
   logic [ADDR_W-1:0] fe_rt0;
   logic [ADDR_W-1:0] fe_ra1;
   logic [ADDR_W-1:0] fe_rb1;
   logic [ADDR_W-1:0] fe_rc1;
   logic [2:0]        fe_src1_vld;
   logic              dep_stall;
   logic              flush;
   logic [INST_W-1:0] iss_inst_ep;
   logic [INST_W-1:0] iss_inst_op;
   logic              iss_vld_ep;
   logic              iss_vld_op;

   // Fetch/control side: drives the pair and hazard controls, observes issue slots.
   modport master (
      output fe_valid, fe_inst0, fe_inst1, fe_pipe0, fe_pipe1, fe_wr0,
             fe_rt0, fe_ra1, fe_rb1, fe_rc1, fe_src1_vld, dep_stall, flush,
      input  fe_ready, iss_inst_ep, iss_inst_op, iss_vld_ep, iss_vld_op
   );

   // Scheduler side.
   modport slave (
      input  fe_valid, fe_inst0, fe_inst1, fe_pipe0, fe_pipe1, fe_wr0,
             fe_rt0, fe_ra1, fe_rb1, fe_rc1, fe_src1_vld, dep_stall, flush,
      output fe_ready, iss_inst_ep, iss_inst_op, iss_vld_ep, iss_vld_op
   );
endinterface

// File: rtl/issue_sched.sv
// Dual-issue scheduler between fetch and decode: buffers one pair, steers each
// instruction to the even/odd pipe, splits on pipe conflict or intra-pair RAW.
// Optional feature macro: ISSUE_STATS_EN (adds saturating issue/stall counters).
module issue_sched #(
   parameter int unsigned       INST_W = 32,
   parameter int unsigned       ADDR_W = 7,
   parameter logic [INST_W-1:0] NOP_EP = INST_W'(32'h4020_0000),
   parameter logic [INST_W-1:0] NOP_OP = INST_W'(32'h0020_0000)
`ifdef ISSUE_STATS_EN
   , parameter int unsigned     CNT_W  = 32
`endif
) (
   input  logic               clk,
   input  logic               rst,
   issue_sched_if.slave       bus
`ifdef ISSUE_STATS_EN
   , output logic [CNT_W-1:0] stat_dual
   , output logic [CNT_W-1:0] stat_single
   , output logic [CNT_W-1:0] stat_stall
`endif
);

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_PAIR   = 2'd1,
      S_SECOND = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [INST_W-1:0] inst0_q, inst0_d;
   logic [INST_W-1:0] inst1_q, inst1_d;
   logic              pipe0_q, pipe0_d;
   logic              pipe1_q, pipe1_d;
   logic              split_q, split_d;
   logic [INST_W-1:0] ep_q, ep_d;
   logic [INST_W-1:0] op_q, op_d;
   logic              vep_q, vep_d;
   logic              vop_q, vop_d;

   logic [ADDR_W-1:0] rt0_c;
   logic              raw_c;
   logic              split_c;
   logic              last_c;
   logic              fe_ready_c;
   logic              accept_c;
   logic              load_c;

   // Split decision for the incoming pair: same pipe class or inst1 reads inst0's rt.
   always_comb begin
      rt0_c   = bus.fe_rt0;
      raw_c   = bus.fe_wr0 & ((bus.fe_src1_vld[2] & (bus.fe_ra1 == rt0_c)) |
                              (bus.fe_src1_vld[1] & (bus.fe_rb1 == rt0_c)) |
                              (bus.fe_src1_vld[0] & (bus.fe_rc1 == rt0_c)));
      split_c = (bus.fe_pipe0 == bus.fe_pipe1) | raw_c;
   end

   // Handshake: a pair is taken when nothing remains pending after this cycle's issue.
   always_comb begin
      last_c     = (state_q == S_SECOND) | ((state_q == S_PAIR) & ~split_q);
      fe_ready_c = rst & ~bus.flush & ~bus.dep_stall & ((state_q == S_EMPTY) | last_c);
      accept_c   = bus.fe_valid & fe_ready_c;
      load_c     = ~bus.flush & ~bus.dep_stall;
   end

   // Next-state, buffer and issue-slot computation.
   always_comb begin
      state_d = state_q;
      inst0_d = inst0_q;
      inst1_d = inst1_q;
      pipe0_d = pipe0_q;
      pipe1_d = pipe1_q;
      split_d = split_q;
      ep_d    = ep_q;
      op_d    = op_q;
      vep_d   = vep_q;
      vop_d   = vop_q;

      if (bus.flush) begin
         state_d = S_EMPTY;
         ep_d    = NOP_EP;
         op_d    = NOP_OP;
         vep_d   = 1'b0;
         vop_d   = 1'b0;
      end else if (!bus.dep_stall) begin
         ep_d  = NOP_EP;
         op_d  = NOP_OP;
         vep_d = 1'b0;
         vop_d = 1'b0;
         case (state_q)
            S_PAIR: begin
               if (split_q) begin
                  if (pipe0_q) begin
                     op_d  = inst0_q;
                     vop_d = 1'b1;
                  end else begin
                     ep_d  = inst0_q;
                     vep_d = 1'b1;
                  end
               end else begin
                  ep_d  = pipe0_q ? inst1_q : inst0_q;
                  op_d  = pipe0_q ? inst0_q : inst1_q;
                  vep_d = 1'b1;
                  vop_d = 1'b1;
               end
            end
            S_SECOND: begin
               if (pipe1_q) begin
                  op_d  = inst1_q;
                  vop_d = 1'b1;
               end else begin
                  ep_d  = inst1_q;
                  vep_d = 1'b1;
               end
            end
            default: ;
         endcase

         if ((state_q == S_PAIR) && split_q) begin
            state_d = S_SECOND;
         end else begin
            state_d = accept_c ? S_PAIR : S_EMPTY;
         end

         if (accept_c) begin
            inst0_d = bus.fe_inst0;
            inst1_d = bus.fe_inst1;
            pipe0_d = bus.fe_pipe0;
            pipe1_d = bus.fe_pipe1;
            split_d = split_c;
         end
      end
   end

   // State, buffer and issue registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_EMPTY;
         inst0_q <= '0;
         inst1_q <= '0;
         pipe0_q <= 1'b0;
         pipe1_q <= 1'b0;
         split_q <= 1'b0;
         ep_q    <= NOP_EP;
         op_q    <= NOP_OP;
         vep_q   <= 1'b0;
         vop_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         inst0_q <= inst0_d;
         inst1_q <= inst1_d;
         pipe0_q <= pipe0_d;
         pipe1_q <= pipe1_d;
         split_q <= split_d;
         ep_q    <= ep_d;
         op_q    <= op_d;
         vep_q   <= vep_d;
         vop_q   <= vop_d;
      end
   end

   assign bus.fe_ready    = fe_ready_c;
   assign bus.iss_inst_ep = ep_q;
   assign bus.iss_inst_op = op_q;
   assign bus.iss_vld_ep  = vep_q;
   assign bus.iss_vld_op  = vop_q;

`ifdef ISSUE_STATS_EN
   logic [CNT_W-1:0] dual_q, dual_d;
   logic [CNT_W-1:0] single_q, single_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   // Saturating counters keyed on what the issue registers load this edge.
   always_comb begin
      dual_d   = dual_q;
      single_d = single_q;
      stall_d  = stall_q;
      if (load_c && vep_d && vop_d && !(&dual_q)) begin
         dual_d = dual_q + CNT_W'(1);
      end
      if (load_c && (vep_d ^ vop_d) && !(&single_q)) begin
         single_d = single_q + CNT_W'(1);
      end
      if (bus.dep_stall && !(&stall_q)) begin
         stall_d = stall_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dual_q   <= '0;
         single_q <= '0;
         stall_q  <= '0;
      end else begin
         dual_q   <= dual_d;
         single_q <= single_d;
         stall_q  <= stall_d;
      end
   end

   assign stat_dual   = dual_q;
   assign stat_single = single_q;
   assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_issue_sched.sv
// Randomized and directed bench for issue_sched against a pending-issue-group queue model.
`timescale 1ns/1ps
module tb_issue_sched;

   localparam logic [31:0] F_EP = 32'h4020_0000;
   localparam logic [31:0] F_OP = 32'h0020_0000;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   issue_sched_if bus ();

`ifdef ISSUE_STATS_EN
   logic [31:0] stat_dual, stat_single, stat_stall;
`endif

   issue_sched dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus)
`ifdef ISSUE_STATS_EN
      , .stat_dual   (stat_dual)
      , .stat_single (stat_single)
      , .stat_stall  (stat_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: one entry per future issue cycle; the output is what was last popped.
   typedef struct {
      logic [31:0] ep;
      logic [31:0] op;
      logic        vep;
      logic        vop;
   } grp_t;

   grp_t        mq[$];
   grp_t        cur;
   int unsigned m_dual, m_single, m_stall;

   function automatic grp_t filler();
      grp_t g;
      g.ep = F_EP; g.op = F_OP; g.vep = 1'b0; g.vop = 1'b0;
      return g;
   endfunction

   function automatic grp_t one(input logic [31:0] inst, input logic pipe);
      grp_t g;
      g = filler();
      if (pipe) begin g.op = inst; g.vop = 1'b1; end
      else      begin g.ep = inst; g.vep = 1'b1; end
      return g;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_pair(input logic v, input logic [31:0] i0, input logic [31:0] i1,
                           input logic p0, input logic p1, input logic wr,
                           input logic [6:0] rt, input logic [6:0] ra, input logic [6:0] rb,
                           input logic [6:0] rc, input logic [2:0] sv);
      bus.fe_valid = v;   bus.fe_inst0 = i0; bus.fe_inst1 = i1;
      bus.fe_pipe0 = p0;  bus.fe_pipe1 = p1; bus.fe_wr0 = wr;
      bus.fe_rt0 = rt;    bus.fe_ra1 = ra;   bus.fe_rb1 = rb; bus.fe_rc1 = rc;
      bus.fe_src1_vld = sv;
   endtask

   task automatic idle();
      set_pair(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
   endtask

   task automatic check_outputs();
      chk("iss_inst_ep", bus.iss_inst_ep, cur.ep);
      chk("iss_inst_op", bus.iss_inst_op, cur.op);
      chk("iss_vld_ep", 32'(bus.iss_vld_ep), 32'(cur.vep));
      chk("iss_vld_op", 32'(bus.iss_vld_op), 32'(cur.vop));
`ifdef ISSUE_STATS_EN
      chk("stat_dual", stat_dual, m_dual);
      chk("stat_single", stat_single, m_single);
      chk("stat_stall", stat_stall, m_stall);
`endif
   endtask

   // One clock: called just after a negedge with fe_* already set.
   task automatic step(input logic st, input logic fl);
      logic exp_ready, acc, split;
      bus.dep_stall = st;
      bus.flush     = fl;
      #1;
      exp_ready = ~fl & ~st & (mq.size() <= 1);
      chk("fe_ready", 32'(bus.fe_ready), 32'(exp_ready));
      acc = bus.fe_valid & exp_ready;
      split = (bus.fe_pipe0 == bus.fe_pipe1) ||
              (bus.fe_wr0 && ((bus.fe_src1_vld[2] && bus.fe_ra1 == bus.fe_rt0) ||
                              (bus.fe_src1_vld[1] && bus.fe_rb1 == bus.fe_rt0) ||
                              (bus.fe_src1_vld[0] && bus.fe_rc1 == bus.fe_rt0)));
      @(posedge clk);
      if (st) m_stall++;
      if (fl) begin
         mq.delete();
         cur = filler();
      end else if (!st) begin
         cur = (mq.size() > 0) ? mq.pop_front() : filler();
         if (cur.vep && cur.vop) m_dual++;
         else if (cur.vep || cur.vop) m_single++;
         if (acc) begin
            if (split) begin
               mq.push_back(one(bus.fe_inst0, bus.fe_pipe0));
               mq.push_back(one(bus.fe_inst1, bus.fe_pipe1));
            end else begin
               grp_t g;
               g.ep  = bus.fe_pipe0 ? bus.fe_inst1 : bus.fe_inst0;
               g.op  = bus.fe_pipe0 ? bus.fe_inst0 : bus.fe_inst1;
               g.vep = 1'b1;
               g.vop = 1'b1;
               mq.push_back(g);
            end
         end
      end
      @(negedge clk);
      check_outputs();
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      #1;
      mq.delete();
      cur = filler();
      m_dual = 0; m_single = 0; m_stall = 0;
      chk("rst_ep", bus.iss_inst_ep, 32'h4020_0000);
      chk("rst_op", bus.iss_inst_op, 32'h0020_0000);
      chk("rst_vld", {30'd0, bus.iss_vld_ep, bus.iss_vld_op}, 32'd0);
      chk("rst_ready", 32'(bus.fe_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst = 1'b0;
      bus.dep_stall = 1'b0;
      bus.flush = 1'b0;
      bus.fe_valid = 1'b1;
      idle();
      bus.fe_valid = 1'b1;
      @(negedge clk);
      apply_reset();
      idle();

`ifdef ISSUE_STATS_EN
      // 10 dual pairs with 2 stall cycles in the middle.
      for (int i = 0; i < 10; i++) begin
         if (i == 5) begin
            idle(); step(1'b1, 1'b0); step(1'b1, 1'b0);
         end
         set_pair(1'b1, 32'hA000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 1'b0, 1'b1,
                  1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
         step(1'b0, 1'b0);
      end
      idle(); step(1'b0, 1'b0); step(1'b0, 1'b0);
      chk("stats_dual_lit", stat_dual, 32'd10);
      chk("stats_stall_lit", stat_stall, 32'd2);
      chk("stats_single_lit", stat_single, 32'd0);
`endif

      // Even + odd, no dependency: both slots at edge1.
      set_pair(1'b1, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
      step(1'b0, 1'b0);
      chk("dual_edge0_vld", {30'd0, bus.iss_vld_ep, bus.iss_vld_op}, 32'd0);
      idle(); step(1'b0, 1'b0);
      chk("dual_ep", bus.iss_inst_ep, 32'h1111_1111);
      chk("dual_op", bus.iss_inst_op, 32'h2222_2222);
      chk("dual_vld", {30'd0, bus.iss_vld_ep, bus.iss_vld_op}, 32'd3);
      step(1'b0, 1'b0);

      // Two even instructions: split over two edges.
      set_pair(1'b1, 32'h3333_3333, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
      step(1'b0, 1'b0);
      idle(); #1;
      chk("conflict_ready_lo", 32'(bus.fe_ready), 32'd0);
      step(1'b0, 1'b0);
      chk("conflict_e1_ep", bus.iss_inst_ep, 32'h3333_3333);
      chk("conflict_e1_op", bus.iss_inst_op, 32'h0020_0000);
      chk("conflict_e1_vld", {30'd0, bus.iss_vld_ep, bus.iss_vld_op}, 32'd2);
      step(1'b0, 1'b0);
      chk("conflict_e2_ep", bus.iss_inst_ep, 32'h4444_4444);
      chk("conflict_e2_vld", {30'd0, bus.iss_vld_ep, bus.iss_vld_op}, 32'd2);
      step(1'b0, 1'b0);

      // RAW on r5: inst0 at edge1, inst1 at edge2.
      set_pair(1'b1, 32'h5555_5555, 32'h6666_6666, 1'b0, 1'b1, 1'b1, 7'd5, 7'd5, 7'd9, 7'd9, 3'b100);
      step(1'b0, 1'b0);
      idle(); step(1'b0, 1'b0);
      chk("raw_e1_ep", bus.iss_inst_ep, 32'h5555_5555);
      chk("raw_e1_vld", {30'd0, bus.iss_vld_ep, bus.iss_vld_op}, 32'd2);
      step(1'b0, 1'b0);
      chk("raw_e2_op", bus.iss_inst_op, 32'h6666_6666);
      chk("raw_e2_ep", bus.iss_inst_ep, 32'h4020_0000);
      chk("raw_e2_vld", {30'd0, bus.iss_vld_ep, bus.iss_vld_op}, 32'd1);
      step(1'b0, 1'b0);

      // Stall three cycles with a pair issued and another pending.
      set_pair(1'b1, 32'h7777_7777, 32'h8888_8888, 1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
      step(1'b0, 1'b0);
      set_pair(1'b1, 32'h9999_9999, 32'hAAAA_AAAA, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
      step(1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0);
         chk("stall_hold_ep", bus.iss_inst_ep, 32'h8888_8888);
         chk("stall_hold_op", bus.iss_inst_op, 32'h7777_7777);
      end
      idle(); step(1'b0, 1'b0);
      chk("stall_next_ep", bus.iss_inst_ep, 32'h9999_9999);
      chk("stall_next_op", bus.iss_inst_op, 32'hAAAA_AAAA);
      step(1'b0, 1'b0);

      // Flush while inst1 pending, with a pair offered.
      set_pair(1'b1, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 1'b1, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
      step(1'b0, 1'b0);
      idle(); step(1'b0, 1'b0);
      set_pair(1'b1, 32'hDDDD_DDDD, 32'hEEEE_EEEE, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
      step(1'b0, 1'b1);
      chk("flush_ep", bus.iss_inst_ep, 32'h4020_0000);
      chk("flush_op", bus.iss_inst_op, 32'h0020_0000);
      chk("flush_vld", {30'd0, bus.iss_vld_ep, bus.iss_vld_op}, 32'd0);
      idle(); step(1'b0, 1'b0);
      chk("flush_drop_vld", {30'd0, bus.iss_vld_ep, bus.iss_vld_op}, 32'd0);

      // Reset mid-operation with a pair pending.
      set_pair(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000);
      step(1'b0, 1'b0);
      apply_reset();
      idle();
      step(1'b0, 1'b0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         set_pair(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  7'($urandom_range(0, 3)), 7'($urandom_range(0, 3)), 7'($urandom_range(0, 3)),
                  7'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
         step(($urandom_range(0, 99) < 15) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
